// File: rtl/serial_arith_pkg.sv
// Shared definitions for the serial arithmetic stages: FSM encoding and the
// default operand width.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bit_serial_adder_fa.sv
// Single full-adder cell; the only arithmetic in the serial adder datapath.
// Also exposes the propagate term so the caller can build a word-level flag.
module bit_serial_adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o,
  output logic prop_o
);

  assign prop_o = a_i ^ b_i;
  assign sum_o  = prop_o ^ cin_i;
  assign cout_o = (a_i & b_i) | (prop_o & cin_i);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: operands stream LSB-first through one full-adder cell,
// one bit per clock, with valid/ready handshakes on both sides.
module bit_serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             all_prop
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  // The LSB of the sum shift register would only ever fall off on the final
  // shift, which lands directly in sum_q, so only WIDTH-1 bits are kept.
  logic [WIDTH-2:0]   sum_sr_q, sum_sr_d;
  logic               carry_q, carry_d;
  logic               prop_acc_q, prop_acc_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               overflow_q, overflow_d;
  logic               all_prop_q, all_prop_d;

  logic               fa_sum;
  logic               fa_cout;
  logic               fa_prop;
  logic [WIDTH-1:0]   sum_shift;

  bit_serial_adder_fa u_fa (
    .a_i    (a_sr_q[0]),
    .b_i    (b_sr_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout),
    .prop_o (fa_prop)
  );

  assign sum_shift = {fa_sum, sum_sr_q};

  always_comb begin
    state_d    = state_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    sum_sr_d   = sum_sr_q;
    carry_d    = carry_q;
    prop_acc_d = prop_acc_q;
    bit_cnt_d  = bit_cnt_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    all_prop_d = all_prop_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d     = a;
          b_sr_d     = b;
          carry_d    = cin;
          prop_acc_d = 1'b1;
          bit_cnt_d  = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        a_sr_d     = a_sr_q >> 1;
        b_sr_d     = b_sr_q >> 1;
        sum_sr_d   = sum_shift[WIDTH-1:1];
        carry_d    = fa_cout;
        prop_acc_d = prop_acc_q & fa_prop;
        if (bit_cnt_q == LAST_BIT) begin
          // carry_q is still the carry into the MSB on this cycle.
          sum_d      = sum_shift;
          cout_d     = fa_cout;
          overflow_d = carry_q ^ fa_cout;
          all_prop_d = prop_acc_q & fa_prop;
          state_d    = DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      sum_sr_q   <= '0;
      carry_q    <= 1'b0;
      prop_acc_q <= 1'b0;
      bit_cnt_q  <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      all_prop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      sum_sr_q   <= sum_sr_d;
      carry_q    <= carry_d;
      prop_acc_q <= prop_acc_d;
      bit_cnt_q  <= bit_cnt_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
      all_prop_q <= all_prop_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;
  assign all_prop  = all_prop_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder at WIDTH=8: table-driven vectors
// through a result scoreboard, plus backpressure and mid-run reset sequences.
module tb_bit_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         ap;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         ap;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         all_prop;

  int   total;
  int   bad;
  exp_t exp_q[$];
  vec_t vecs[9];

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .all_prop  (all_prop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    exp_t     e;
    logic [W:0] full;
    full   = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]);
    e.ap   = &(av ^ bv);
    return e;
  endfunction

  // Returns just after the accept edge with in_valid dropped.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input exp_t e);
    int waited = 0;
    while (!in_ready && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    cin      = cv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic collect(input string tag, input bit chk_lat, input bit ack);
    int   cnt = 0;
    exp_t e;
    while (!out_valid && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    if (!out_valid) begin
      check({tag, "_timeout"}, 32'(out_valid), 32'd1);
    end
    if (chk_lat) check({tag, "_latency"}, 32'(cnt), 32'(W));
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_sum"},      32'(sum),      32'(e.sum));
    check({tag, "_cout"},     32'(cout),     32'(e.cout));
    check({tag, "_overflow"}, 32'(overflow), 32'(e.ovf));
    check({tag, "_all_prop"}, 32'(all_prop), 32'(e.ap));
    $display("txn %s: sum=%02h cout=%0d ovf=%0d all_prop=%0d latency=%0d",
             tag, sum, cout, overflow, all_prop, cnt);
    if (ack) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check({tag, "_ack_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_ack_in_ready"},  32'(in_ready),  32'd1);
    end
  endtask

  initial begin
    logic [W-1:0] held_sum;
    logic         held_cout;
    bit           seen;

    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0};

    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_outputs",   32'({sum, cout, overflow, all_prop}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table vectors; the first runs with out_ready low, the rest leave it high
    // so it is also exercised outside DONE.
    for (int i = 0; i < 9; i++) begin
      exp_t e;
      e.sum  = vecs[i].sum;
      e.cout = vecs[i].cout;
      e.ovf  = vecs[i].ovf;
      e.ap   = vecs[i].ap;
      send(vecs[i].a, vecs[i].b, vecs[i].cin, e);
      collect($sformatf("vec%0d", i), 1'b1, 1'b1);
    end

    // Backpressure: hold DONE for 5 cycles while offering new operands.
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0, model(8'h12, 8'h34, 1'b0));
    collect("bp_first", 1'b1, 1'b0);
    held_sum  = sum;
    held_cout = cout;
    in_valid  = 1'b1;
    a         = 8'hFF;
    b         = 8'hFF;
    cin       = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_hold",      32'({sum, cout}), 32'({held_sum, held_cout}));
    end
    check("bp_held_value", 32'(held_sum), 32'h46);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready",  32'(in_ready),  32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    send(8'hFF, 8'hFF, 1'b0, model(8'hFF, 8'hFF, 1'b0));
    collect("bp_second", 1'b1, 1'b1);

    // Reset while RUN is at bit 3: result must be discarded.
    send(8'h55, 8'h66, 1'b0, model(8'h55, 8'h66, 1'b0));
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    seen = 1'b0;
    check("mid_rst_outputs", 32'({out_valid, sum, cout, overflow, all_prop}), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_result", 32'(seen), 32'd0);
    check("mid_rst_outputs_after", 32'({sum, cout, overflow, all_prop}), 32'd0);
    send(8'h03, 8'h04, 1'b0, model(8'h03, 8'h04, 1'b0));
    collect("after_rst", 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
